// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned MemBytesDefault = 1000;
    localparam int unsigned WordBits        = 32;
    localparam int unsigned ByteBits        = 8;
    localparam int unsigned BytesPerWord    = WordBits / ByteBits;
    localparam int unsigned IdxBits         = 2;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StFinish
    } imem_state_e;

    // True when a whole word starting at ptr still lies inside memory; 33-bit so it cannot wrap.
    function automatic logic word_fits(input logic [31:0] ptr, input int unsigned mem_bytes);
        return ({1'b0, ptr} + 33'(BytesPerWord)) <= {1'b0, mem_bytes};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Word source / memory write port bundle for imem_loader; the loader sits on the slave side.
interface imem_loader_if;
    import imem_pkg::*;

    logic                start;
    logic [15:0]         nwords;
    logic                wvalid;
    logic [WordBits-1:0] wdata;
    logic                wready;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [ByteBits-1:0] mem_data;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [31:0]         csum;

    modport master (
        output start, nwords, wvalid, wdata,
        input  wready, mem_we, mem_addr, mem_data, busy, done, ovf, csum
    );

    modport slave (
        input  start, nwords, wvalid, wdata,
        output wready, mem_we, mem_addr, mem_data, busy, done, ovf, csum
    );

endinterface

// File: rtl/imem_byte_ser.sv
// Big-endian byte selection: idx 0 returns the most significant byte of the word.
module imem_byte_ser
    import imem_pkg::*;
(
    input  logic [WordBits-1:0] word,
    input  logic [IdxBits-1:0]  idx,
    output logic [ByteBits-1:0] sel_byte
);

    always_comb begin
        sel_byte = '0;
        unique case (idx)
            2'd0: sel_byte = word[31:24];
            2'd1: sel_byte = word[23:16];
            2'd2: sel_byte = word[15:8];
            2'd3: sel_byte = word[7:0];
            default: sel_byte = '0;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-wide instruction memory, one word per 5 cycles.
// Define IMEM_LOADER_CSUM_EN to get a running modulo-2^32 word checksum on csum.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MemBytesDefault,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_loader_if.slave bus
);

    imem_state_e         state_q, state_d;
    logic [31:0]         ptr_q, ptr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         nwords_q, nwords_d;
    logic [WordBits-1:0] word_q, word_d;
    logic [IdxBits-1:0]  idx_q, idx_d;
    logic                wready_q, wready_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [ByteBits-1:0] mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [WordBits-1:0] ser_word;
    logic [IdxBits-1:0]  ser_idx;
    logic [ByteBits-1:0] ser_byte;

    // Outputs are registered, so the serializer looks one byte ahead of what is on the bus.
    assign ser_word = (state_q == StAccept) ? bus.wdata : word_q;
    assign ser_idx  = (state_q == StAccept) ? '0 : idx_q + 2'd1;

    imem_byte_ser u_byte_ser (
        .word     (ser_word),
        .idx      (ser_idx),
        .sel_byte (ser_byte)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        nwords_d   = nwords_q;
        word_d     = word_q;
        idx_d      = idx_q;
        wready_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ptr_d    = BASE_ADDR;
                    cnt_d    = '0;
                    nwords_d = bus.nwords;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (bus.nwords == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d  = StAccept;
                        wready_d = word_fits(BASE_ADDR, MEM_BYTES);
                    end
                end
            end

            StAccept: begin
                // wready_q was loaded with the fit check for ptr_q on entry to this state.
                if (!wready_q) begin
                    ovf_d   = 1'b1;
                    state_d = StFinish;
                end else if (bus.wvalid) begin
                    word_d     = bus.wdata;
                    idx_d      = '0;
                    state_d    = StWrite;
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = ser_byte;
                end else begin
                    wready_d = 1'b1;
                end
            end

            StWrite: begin
                if (idx_q == 2'd3) begin
                    ptr_d = ptr_q + 32'(BytesPerWord);
                    cnt_d = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == nwords_q) begin
                        state_d = StFinish;
                    end else begin
                        state_d  = StAccept;
                        wready_d = word_fits(ptr_q + 32'(BytesPerWord), MEM_BYTES);
                    end
                end else begin
                    idx_d      = idx_q + 2'd1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q + 32'(idx_q) + 32'd1;
                    mem_data_d = ser_byte;
                end
            end

            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            nwords_q   <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            wready_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            nwords_q   <= nwords_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            wready_q   <= wready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic        csum_clr;
    logic        csum_add;
    logic [31:0] csum_q;

    assign csum_clr = (state_q == StIdle) && bus.start;
    assign csum_add = (state_q == StAccept) && wready_q && bus.wvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (csum_clr) begin
            csum_q <= '0;
        end else if (csum_add) begin
            csum_q <= csum_q + bus.wdata;
        end
    end

    assign bus.csum = csum_q;
`else
    assign bus.csum = '0;
`endif

    assign bus.wready   = wready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1000, meaning instruction memory size in bytes.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning first byte address written after START.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: CLK (clock) and RST_N (reset).
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 START  input  1  single-cycle pulse; begins a load session.
REQ-007 NWORDS  input  16  word count for the session; sampled only on accepted START.
REQ-008 WVALID  input  1  source has a 32-bit instruction word on WDATA.
REQ-009 WDATA  input  32  instruction word; bit 31 is the most significant bit.
REQ-010 WREADY  output  1  loader accepts WDATA this cycle.
REQ-011 MEM_WE  output  1  byte write strobe to instruction memory.
REQ-012 MEM_ADDR  output  32  byte address of the current write.
REQ-013 MEM_DATA  output  8  byte being written.
REQ-014 BUSY  output  1  session in progress.
REQ-015 DONE  output  1  one-cycle pulse at session end.
REQ-016 OVF  output  1  sticky; session ended because the next word would not fit in memory.
REQ-017 CSUM  output  32  running checksum (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, ACCEPT, WRITE, FINISH; all outputs SHALL be registered.
REQ-019 IDLE: START=1 SHALL set ptr=BASE_ADDR, cnt=0, latch NWORDS, clear OVF, enter ACCEPT (or FINISH if NWORDS=0); BUSY=1 from next cycle.
REQ-020 START while BUSY=1 SHALL be ignored.
REQ-021 ACCEPT: WREADY=1 only if ptr+4 <= MEM_BYTES; else WREADY=0, OVF<=1, go FINISH.
REQ-022 A transfer SHALL occur only on the cycle WVALID=1 and WREADY=1; word captured, WREADY drops next cycle, go WRITE with idx=0.
REQ-023 WRITE SHALL take exactly 4 cycles, idx 0..3: MEM_WE=1, MEM_ADDR=ptr+idx, MEM_DATA=word[31-8*idx -: 8] (big-endian: MSB at lowest address).
REQ-024 After idx=3: ptr+=4, cnt+=1; cnt==NWORDS -> FINISH else ACCEPT; sustained throughput one word per 5 cycles.
REQ-025 FINISH SHALL last one cycle: DONE=1, BUSY=0 on the same edge, then IDLE.
REQ-026 ptr arithmetic SHALL be 32-bit and SHALL NOT wrap; the MEM_BYTES check in REQ-021 is the only bound.
REQ-027 MEM_WE SHALL be 0 in every state other than WRITE.

Reset
REQ-028 RST_N=0 SHALL immediately force IDLE, WREADY=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, BUSY=0, DONE=0, OVF=0, CSUM=0, cnt=0.
REQ-029 Reset during WRITE SHALL abort the word with no further MEM_WE; bytes already written are not rolled back.

Configuration
REQ-030 With macro IMEM_LOADER_CSUM_EN defined, CSUM SHALL be the modulo-2^32 sum of all words accepted this session, cleared on accepted START.
REQ-031 Without IMEM_LOADER_CSUM_EN, CSUM SHALL be constant 0 and no adder SHALL be synthesized.

Structure
REQ-032 Package imem_pkg SHALL hold the FSM state typedef, the default MEM_BYTES (1000), and the word/byte width constants.
REQ-033 Word-to-byte selection SHALL reside in sub-module imem_byte_ser (inputs word and idx, output byte); all sequencing stays in imem_loader.

Verification
REQ-034 START, NWORDS=1, WDATA=0x12345678 -> four MEM_WE cycles at addr 0..3 with data 0x12,0x34,0x56,0x78; DONE pulse next cycle.
REQ-035 NWORDS=3, WVALID held high -> WREADY accepts at 5-cycle spacing; last write at addr 11; CSUM equals the word sum with IMEM_LOADER_CSUM_EN, else 0.
REQ-036 BASE_ADDR=992, NWORDS=3 -> words at 992 and 996 written; third not accepted; OVF=1; DONE pulse.
REQ-037 NWORDS=0 -> no WREADY, no MEM_WE, DONE one cycle after BUSY rises.
REQ-038 RST_N low at WRITE idx=1 -> MEM_WE=0 immediately, BUSY=0, no further writes; new START restarts at BASE_ADDR.
